jtframe_pocket_upload: RTL and testbench
========================================

JTFRAME_POCKET_UPLOAD -- requirements
Module: jtframe_pocket_upload

Interface
REQ-001 SHALL have parameter AW, default 25: ioctl byte-address width.
REQ-002 SHALL have parameter WIN, default 4'h2: bridge_addr[31:28] value that selects the upload window.
REQ-003 SHALL have parameter RD_LAT, default 2, range 1..7: ioctl_din read latency in clk cycles.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port upload_en  input  1  host enables NVRAM/RAM upload session.
REQ-007 SHALL have port bridge_addr  input  32  bridge read byte address, clk-synchronous.
REQ-008 SHALL have port bridge_rd  input  1  one-cycle read strobe, clk-synchronous.
REQ-009 SHALL have port bridge_rd_data  output  32  registered read word, big-endian.
REQ-010 SHALL have port ioctl_addr  output  AW  byte address presented to game memory.
REQ-011 SHALL have port ioctl_din  input  8  byte returned by game memory RD_LAT cycles after ioctl_addr.
REQ-012 SHALL have port ioctl_ram  output  1  tells game to route ioctl_addr/ioctl_din to its RAM.
REQ-013 SHALL have port busy  output  1  word fetch in progress.
REQ-014 SHALL have port drop_cnt  output  8  saturating count of ignored reads.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, DONE.
REQ-016 In IDLE, bridge_rd=1 with upload_en=1 and bridge_addr[31:28]==WIN SHALL latch base=bridge_addr[AW-1:0] with bits[1:0] forced to 0, set byte index k=0, set busy=1, and go to FETCH.
REQ-017 In IDLE, bridge_rd=1 outside the window, or with upload_en=0, SHALL load bridge_rd_data=0 on the next edge and SHALL NOT start a fetch.
REQ-018 In FETCH, ioctl_addr SHALL equal (base+k) mod 2^AW, registered, stable for RD_LAT+1 cycles per byte.
REQ-019 ioctl_din SHALL be captured on the (RD_LAT+1)-th edge after ioctl_addr changes.
REQ-020 Byte k SHALL be stored in lane [31-8k -: 8], so base+0 lands in [31:24].
REQ-021 After capturing k=3, the FSM SHALL go to DONE.
REQ-022 DONE SHALL last one cycle: load bridge_rd_data from the assembly register, clear busy, and return to IDLE.
REQ-023 Latency from the bridge_rd edge to the updated bridge_rd_data and busy=0 SHALL be exactly 4*(RD_LAT+1)+1 cycles (13 at default).
REQ-024 bridge_rd_data SHALL change only in DONE or per REQ-017; it SHALL hold otherwise.
REQ-025 bridge_rd while busy=1 SHALL be ignored and SHALL increment drop_cnt, saturating at 255.
REQ-026 upload_en falling during FETCH SHALL abort: next edge returns to IDLE, busy=0, bridge_rd_data unchanged, no drop_cnt change.
REQ-027 ioctl_ram SHALL be a registered copy of upload_en (one-cycle delay).
REQ-028 In IDLE, ioctl_addr SHALL hold its last value.
REQ-029 Address wrap SHALL be modulo 2^AW: base=2^AW-4 reads bytes 2^AW-4..2^AW-1 with no carry beyond AW.

Reset
REQ-030 While rst=1, the FSM SHALL be in IDLE, and bridge_rd_data=0, ioctl_addr=0, ioctl_ram=0, busy=0, drop_cnt=0, with the assembly register and counters cleared.
REQ-031 rst asserted mid-FETCH SHALL abort immediately, with no partial word visible on bridge_rd_data after release.
REQ-032 After rst deasserts, the first bridge_rd SHALL be accepted on the first clk edge.

Verification
REQ-033 Memory model with RD_LAT=2, byte[a]=a[7:0]^8'h5A; upload_en=1; bridge_rd at 0x2000_0010 -> ioctl_addr 0x10,0x11,0x12,0x13, each for 3 cycles; bridge_rd_data=32'h4A4B4849 13 cycles after the strobe; busy high for exactly 12 cycles.
REQ-034 bridge_rd at 0x3000_0000, then at 0x2000_0010 with upload_en=0 -> bridge_rd_data=0 the next cycle each time; busy stays 0; ioctl_addr unchanged.
REQ-035 Unaligned bridge_rd at 0x2000_0013 -> same fetch sequence and result as 0x2000_0010.
REQ-036 Three extra bridge_rd pulses during a fetch -> drop_cnt=3; the original word completes correctly; 300 dropped pulses -> drop_cnt=255.
REQ-037 bridge_rd at 0x21FF_FFFC (AW=25) -> ioctl_addr 0x1FFFFFC..0x1FFFFFF, with no wrap into bits above AW.
REQ-038 upload_en dropped 5 cycles into a fetch, and separately rst pulsed 5 cycles into a fetch -> busy=0 within 1 cycle, or immediately for rst; bridge_rd_data holds its prior value (0 after rst); the next read succeeds.

Source files
------------

// File: rtl/jtframe_pocket_upload.sv
// Bridge-to-ioctl upload reader: a bridge read inside the upload window fetches
// four consecutive bytes from game memory over the ioctl port. It then returns
// them as one big-endian word on bridge_rd_data.
//
// Handshake: bridge_rd is a one-cycle strobe sampled on a rising edge. In IDLE a
// strobe is either accepted (busy rises on the same edge) or rejected (data
// reads back 0 on the next edge). While a fetch is running, strobes are dropped
// and counted. busy falls on the edge that enters DONE. The fetched word shows
// up on the following edge, 4*(RD_LAT+1)+1 edges after the accepting edge.
module jtframe_pocket_upload #(
    parameter int          AW     = 25,
    parameter logic [3:0]  WIN    = 4'h2,
    parameter int          RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          upload_en,
    input  logic [31:0]   bridge_addr,
    input  logic          bridge_rd,
    output logic [31:0]   bridge_rd_data,
    output logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_din,
    output logic          ioctl_ram,
    output logic          busy,
    output logic [7:0]    drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [1:0]  k;        // byte index inside the word
    logic [2:0]  cnt;      // cycles spent on the current byte
    logic [31:0] asm_q;    // word being assembled
    logic        accept;
    logic        reject;
    logic        capture;

    // Only the window nibble and the low AW bits matter. The rest is intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bridge_addr;

    // busy is high exactly while bytes are being fetched.
    assign busy = (state == FETCH);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode plus the per-cycle datapath strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (bridge_rd) begin
                    if (upload_en && bridge_addr[31:28] == WIN) begin
                        accept     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            FETCH: begin
                // Losing the upload session abandons the word without touching the output.
                if (!upload_en) begin
                    state_next = IDLE;
                end else if (cnt == 3'(RD_LAT)) begin
                    capture = 1'b1;
                    if (k == 2'd3) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address walk, byte capture and output word update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ioctl_addr     <= '0;
            k              <= 2'd0;
            cnt            <= 3'd0;
            asm_q          <= 32'd0;
            bridge_rd_data <= 32'd0;
        end else begin
            if (accept) begin
                ioctl_addr <= {bridge_addr[AW-1:2], 2'b00};
                k          <= 2'd0;
                cnt        <= 3'd0;
                asm_q      <= 32'd0;
            end else if (state == FETCH) begin
                if (capture) begin
                    case (k)
                        2'd0:    asm_q[31:24] <= ioctl_din;
                        2'd1:    asm_q[23:16] <= ioctl_din;
                        2'd2:    asm_q[15:8]  <= ioctl_din;
                        default: asm_q[7:0]   <= ioctl_din;
                    endcase
                    // The base is word aligned, so +1 never carries past bit 1 within a word.
                    if (k != 2'd3) begin
                        k          <= k + 2'd1;
                        ioctl_addr <= ioctl_addr + AW'(1);
                    end
                    cnt <= 3'd0;
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end

            if (reject)              bridge_rd_data <= 32'd0;
            else if (state == DONE)  bridge_rd_data <= asm_q;
        end
    end

    // Count strobes that arrive while a word is in flight, saturating at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (bridge_rd && state != IDLE && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Registered copy of the session enable for the game's memory mux
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ioctl_ram <= 1'b0;
        else     ioctl_ram <= upload_en;
    end

endmodule

// File: tb/tb_jtframe_pocket_upload.sv
// Directed bench for jtframe_pocket_upload with a two-cycle-latency memory model.
module tb_jtframe_pocket_upload;

    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          rst;
    logic          upload_en;
    logic [31:0]   bridge_addr;
    logic          bridge_rd;
    logic [31:0]   bridge_rd_data;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_ram;
    logic          busy;
    logic [7:0]    drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_data;

    jtframe_pocket_upload #(.AW(AW), .WIN(4'h2), .RD_LAT(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .upload_en      (upload_en),
        .bridge_addr    (bridge_addr),
        .bridge_rd      (bridge_rd),
        .bridge_rd_data (bridge_rd_data),
        .ioctl_addr     (ioctl_addr),
        .ioctl_din      (ioctl_din),
        .ioctl_ram      (ioctl_ram),
        .busy           (busy),
        .drop_cnt       (drop_cnt)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // Memory model: byte[a] = a[7:0] ^ 8'h5A, valid two cycles after the address
    logic [7:0] mem_p1;
    always @(posedge clk) begin
        mem_p1    <= ioctl_addr[7:0] ^ 8'h5A;
        ioctl_din <= mem_p1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge. It issues a window read, then follows the fetch cycle by cycle.
    task automatic run_fetch(input logic [31:0] addr, input logic [31:0] exp_base,
                             input logic [31:0] exp_data, input bit with_drops);
        int busy_cycles;
        busy_cycles = 0;
        bridge_addr = addr;
        bridge_rd   = 1'b1;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            bridge_rd = with_drops && (n == 1 || n == 3 || n == 5);
            if (busy) busy_cycles++;
            if (n < 12)  check("fetch_addr", 32'(ioctl_addr), exp_base + 32'(n / 3));
            if (n == 12) check("data_hold", bridge_rd_data, model_data);
        end
        bridge_rd = 1'b0;
        check("busy_len", 32'(busy_cycles), 32'd12);
        check("fetch_data", bridge_rd_data, exp_data);
        check("addr_idle_hold", 32'(ioctl_addr), exp_base + 32'd3);
        model_data = exp_data;
    endtask

    // Called at a falling edge. It issues a read that must be refused.
    task automatic reject_read(input logic [31:0] addr, input logic [31:0] exp_ioctl);
        bridge_addr = addr;
        bridge_rd   = 1'b1;
        @(negedge clk);
        bridge_rd = 1'b0;
        check("rej_data", bridge_rd_data, 32'd0);
        check("rej_busy", 32'(busy), 32'd0);
        check("rej_addr", 32'(ioctl_addr), exp_ioctl);
        @(negedge clk);
        check("rej_busy_later", 32'(busy), 32'd0);
        model_data = 32'd0;
    endtask

    initial begin
        rst         = 1'b1;
        upload_en   = 1'b0;
        bridge_addr = 32'd0;
        bridge_rd   = 1'b0;
        model_data  = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_data", bridge_rd_data, 32'd0);
        check("rst_addr", 32'(ioctl_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_ram", 32'(ioctl_ram), 32'd0);
        rst       = 1'b0;
        upload_en = 1'b1;
        @(negedge clk);
        check("ioctl_ram_on", 32'(ioctl_ram), 32'd1);

        // Basic fetch, then an out-of-window refusal
        run_fetch(32'h2000_0010, 32'h10, 32'h4A4B4849, 1'b0);
        @(negedge clk);
        reject_read(32'h3000_0000, 32'h13);

        // Unaligned address gives the same word
        run_fetch(32'h2000_0013, 32'h10, 32'h4A4B4849, 1'b0);

        // Session disabled: refused
        @(negedge clk);
        upload_en = 1'b0;
        @(negedge clk);
        check("ioctl_ram_off", 32'(ioctl_ram), 32'd0);
        reject_read(32'h2000_0010, 32'h13);
        upload_en = 1'b1;
        @(negedge clk);

        // Three strobes dropped during a fetch
        run_fetch(32'h2000_0020, 32'h20, 32'h7A7B7879, 1'b1);
        check("drop_three", 32'(drop_cnt), 32'd3);

        // Continuous strobing: many drops saturate the counter
        @(negedge clk);
        bridge_addr = 32'h2000_0030;
        bridge_rd   = 1'b1;
        repeat (400) @(negedge clk);
        bridge_rd = 1'b0;
        repeat (20) @(negedge clk);
        check("drop_sat", 32'(drop_cnt), 32'd255);
        check("sat_busy", 32'(busy), 32'd0);
        check("sat_data", bridge_rd_data, 32'h6A6B6869);
        model_data = 32'h6A6B6869;

        // Top of the address space
        run_fetch(32'h21FF_FFFC, 32'h01FF_FFFC, 32'hA6A7A4A5, 1'b0);

        // Reset pulsed in the middle of a fetch
        @(negedge clk);
        bridge_addr = 32'h2000_0010;
        bridge_rd   = 1'b1;
        @(negedge clk);
        bridge_rd = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_data", bridge_rd_data, 32'd0);
        check("rst_mid_addr", 32'(ioctl_addr), 32'd0);
        check("rst_mid_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        model_data = 32'd0;
        run_fetch(32'h2000_0010, 32'h10, 32'h4A4B4849, 1'b0);

        // Upload session dropped in the middle of a fetch
        @(negedge clk);
        bridge_addr = 32'h2000_0020;
        bridge_rd   = 1'b1;
        @(negedge clk);
        bridge_rd = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        upload_en = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", bridge_rd_data, model_data);
        check("abort_drop", 32'(drop_cnt), 32'd0);
        upload_en = 1'b1;
        @(negedge clk);
        run_fetch(32'h2000_0020, 32'h20, 32'h7A7B7879, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
